// File: rtl/fm_modulator_s.sv
// rtl/fm_modulator_s.sv - FM modulator: scaled sample accumulated into a phase register, I/Q from a quarter-wave sine ROM.
// One call per ap_start; five-state one-hot FSM reads the ROM twice (sin, then cos) per call.
module fm_modulator_s #(
   parameter int          PHASE_W = 24,
   parameter int          LUT_AW  = 8,
   parameter logic [15:0] KF      = 16'h0800
) (
   input  logic              ap_clk,
   input  logic              ap_rst,
   input  logic              ap_start,
   output logic              ap_done,
   output logic              ap_idle,
   output logic              ap_ready,
   input  logic [15:0]       x_V,
   output logic [LUT_AW-1:0] sin_lut_V_address0,
   output logic              sin_lut_V_ce0,
   input  logic [15:0]       sin_lut_V_q0,
   output logic [15:0]       i_out_V,
   output logic [15:0]       q_out_V
);

   localparam int SH = 32 - PHASE_W;

   typedef enum logic [4:0] {
      S_IDLE = 5'b00001,
      S_INC  = 5'b00010,
      S_RD_S = 5'b00100,
      S_RD_C = 5'b01000,
      S_DONE = 5'b10000
   } state_t;

   state_t               state_q;
   logic [PHASE_W-1:0]   phase_q, phase_d;
   logic [15:0]          sin_mag_q;
   logic [15:0]          i_hold_q, q_hold_q;

   logic signed [31:0]   x_ext, kf_ext, prod;
   logic [1:0]           quad;
   logic [LUT_AW-1:0]    idx, sin_addr, cos_addr;
   logic                 sin_neg, cos_neg;
   logic [15:0]          sin_s, cos_s;

   // Q2.14 * Q2.14 -> Q4.28; the arithmetic shift keeps the phase increment signed.
   assign x_ext   = {{16{x_V[15]}}, x_V};
   assign kf_ext  = {{16{KF[15]}}, KF};
   assign prod    = x_ext * kf_ext;
   assign phase_d = phase_q + PHASE_W'(prod >>> SH);

   assign quad     = phase_q[PHASE_W-1 -: 2];
   assign idx      = phase_q[PHASE_W-3 -: LUT_AW];
   assign sin_addr = quad[0] ? ~idx : idx;
   assign cos_addr = quad[0] ? idx : ~idx;
   assign sin_neg  = quad[1];
   assign cos_neg  = quad[1] ^ quad[0];

   assign sin_s = sin_neg ? (~sin_mag_q + 16'd1) : sin_mag_q;
   assign cos_s = cos_neg ? (~sin_lut_V_q0 + 16'd1) : sin_lut_V_q0;

   assign sin_lut_V_ce0      = (state_q == S_RD_S) || (state_q == S_RD_C);
   assign sin_lut_V_address0 = (state_q == S_RD_C) ? cos_addr : sin_addr;

   assign ap_done  = (state_q == S_DONE);
   assign ap_ready = (state_q == S_DONE);
   assign ap_idle  = (state_q == S_IDLE) && !ap_start;

   assign i_out_V = (state_q == S_DONE) ? cos_s : i_hold_q;
   assign q_out_V = (state_q == S_DONE) ? sin_s : q_hold_q;

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         state_q   <= S_IDLE;
         phase_q   <= '0;
         sin_mag_q <= '0;
         i_hold_q  <= '0;
         q_hold_q  <= '0;
      end else begin
         case (state_q)
            S_IDLE: if (ap_start) state_q <= S_INC;
            S_INC: begin
               phase_q <= phase_d;
               state_q <= S_RD_S;
            end
            S_RD_S: state_q <= S_RD_C;
            S_RD_C: begin
               sin_mag_q <= sin_lut_V_q0;
               state_q   <= S_DONE;
            end
            S_DONE: begin
               i_hold_q <= cos_s;
               q_hold_q <= sin_s;
               state_q  <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fm_modulator_s.sv
// tb/tb_fm_modulator_s.sv - directed vector bench for fm_modulator_s with a quarter-wave ROM model.
module tb_fm_modulator_s;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        done, idle, ready;
   logic [15:0] x;
   logic [7:0]  addr;
   logic        ce0;
   logic [15:0] q0 = 16'h0000;
   logic [15:0] i_out, q_out;

   logic [15:0] lut [256];
   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   fm_modulator_s dut (
      .ap_clk(clk), .ap_rst(rst), .ap_start(start),
      .ap_done(done), .ap_idle(idle), .ap_ready(ready),
      .x_V(x),
      .sin_lut_V_address0(addr), .sin_lut_V_ce0(ce0), .sin_lut_V_q0(q0),
      .i_out_V(i_out), .q_out_V(q_out)
   );

   always @(posedge clk) if (ce0) q0 <= lut[addr];

   typedef struct {
      logic [15:0] x;
      logic [7:0]  sa;
      logic [7:0]  ca;
      bit          sneg;
      bit          cneg;
   } vec_t;

   vec_t tbl [9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] expv(input logic [7:0] a, input bit neg);
      return neg ? (~lut[a] + 16'd1) : lut[a];
   endfunction

   task automatic do_call(input logic [15:0] xv, output logic [7:0] sa, output logic [7:0] ca,
                          output logic [15:0] iv, output logic [15:0] qv, output int lat);
      bit got_s = 0;
      sa = 8'hxx; ca = 8'hxx; iv = 16'hxxxx; qv = 16'hxxxx; lat = -1;
      @(negedge clk);
      start = 1'b1;
      x = xv;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (c == 1) start = 1'b0;
         if (c == 2) x = ~xv;
         if (ce0) begin
            if (!got_s) begin sa = addr; got_s = 1; end
            else ca = addr;
         end
         if (done) begin
            iv = i_out; qv = q_out; lat = c;
            break;
         end
      end
   endtask

   task automatic run_vec(input string tag, input vec_t v);
      logic [7:0] sa, ca;
      logic [15:0] iv, qv;
      int lat;
      do_call(v.x, sa, ca, iv, qv, lat);
      check({tag, " latency"}, lat, 4);
      check({tag, " sin_addr"}, {24'h0, sa}, {24'h0, v.sa});
      check({tag, " cos_addr"}, {24'h0, ca}, {24'h0, v.ca});
      check({tag, " q_out"}, {16'h0, qv}, {16'h0, expv(v.sa, v.sneg)});
      check({tag, " i_out"}, {16'h0, iv}, {16'h0, expv(v.ca, v.cneg)});
   endtask

   task automatic quiet_call(input logic [15:0] xv);
      logic [7:0] sa, ca;
      logic [15:0] iv, qv;
      int lat;
      do_call(xv, sa, ca, iv, qv, lat);
      if (lat != 4) check("quiet call latency", lat, 4);
   endtask

   task automatic do_reset;
      rst = 1'b1; start = 1'b0; x = 16'h0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int dcyc [$];
      for (int k = 0; k < 256; k++)
         lut[k] = 16'(int'($floor(16384.0 * $sin(3.14159265358979 * k / 512.0) + 0.5)));

      // phase after each row: 0, 020000, 0, FE0000, 0, 000008, 0, 03FFF8, FFFFF8 then x=1 wraps to 0
      tbl[0] = '{16'h0000, 8'h00, 8'hFF, 0, 0};
      tbl[1] = '{16'h4000, 8'h08, 8'hF7, 0, 0};
      tbl[2] = '{16'hC000, 8'h00, 8'hFF, 0, 0};
      tbl[3] = '{16'hC000, 8'h07, 8'hF8, 1, 0};
      tbl[4] = '{16'h4000, 8'h00, 8'hFF, 0, 0};
      tbl[5] = '{16'h0001, 8'h00, 8'hFF, 0, 0};
      tbl[6] = '{16'hFFFF, 8'h00, 8'hFF, 0, 0};
      tbl[7] = '{16'h7FFF, 8'h0F, 8'hF0, 0, 0};
      tbl[8] = '{16'h8000, 8'h00, 8'hFF, 1, 0};

      do_reset();
      @(negedge clk);
      check("reset ap_idle", idle, 1'b1);
      check("reset ap_done", done, 1'b0);
      check("reset ap_ready", ready, 1'b0);
      check("reset ce0", ce0, 1'b0);
      check("reset i_out", i_out, 16'h0);
      check("reset q_out", q_out, 16'h0);

      for (int n = 0; n < 9; n++) run_vec($sformatf("vec%0d", n), tbl[n]);
      run_vec("wrap8", '{16'h0001, 8'h00, 8'hFF, 0, 0});

      for (int n = 0; n < 31; n++) quiet_call(16'h4000);
      run_vec("quarter", '{16'h4000, 8'hFF, 8'h00, 0, 1});
      for (int n = 0; n < 96; n++) quiet_call(16'h4000);
      run_vec("full_wrap", '{16'h0000, 8'h00, 8'hFF, 0, 0});

      @(negedge clk);
      start = 1'b1; x = 16'h0000;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (done) dcyc.push_back(c);
         if (c == 14) start = 1'b0;
      end
      check("b2b done count", dcyc.size(), 3);
      if (dcyc.size() == 3) begin
         check("b2b done0", dcyc[0], 4);
         check("b2b done1", dcyc[1], 9);
         check("b2b done2", dcyc[2], 14);
      end
      check("hold i_out", i_out, lut[255]);
      check("hold q_out", q_out, 16'h0);
      check("hold idle", idle, 1'b1);

      for (int n = 0; n < 5; n++) quiet_call(16'h4000);
      check("pre-reset q_out", q_out, lut[8'h28]);
      @(negedge clk);
      start = 1'b1; x = 16'h4000;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      check("mid ce0 in RD_S", ce0, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst idle", idle, 1'b1);
      check("rst ce0", ce0, 1'b0);
      check("rst done", done, 1'b0);
      check("rst i_out", i_out, 16'h0);
      check("rst q_out", q_out, 16'h0);
      run_vec("post_rst", '{16'h0000, 8'h00, 8'hFF, 0, 0});

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
